// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_res0,
  output logic [31:0] rsp_res1,
  output logic        rsp_zero0,
  output logic        rsp_zero1
);

  logic        iss_valid;
  logic        iss_owner;
  logic [31:0] iss_a;
  logic [31:0] iss_b;
  logic [2:0]  iss_op;
  logic        ptr;

  logic        iss_move;
  logic        iss_free;
  logic [1:0]  grant;
  logic        accept;
  logic        acc_id;

  // The shared ALU sees the issue register directly
  assign alu_a    = iss_a;
  assign alu_b    = iss_b;
  assign alu_ctrl = iss_op;

  // Issue advance, round-robin grant and request handshake
  always_comb begin
    iss_move = iss_valid & (~rsp_valid[iss_owner] | rsp_ready[iss_owner]);
    iss_free = ~iss_valid | iss_move;
    grant    = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    req_ready = iss_free ? grant : 2'b00;
    accept    = |req_ready;
    acc_id    = req_ready[1];
  end

  // Issue register: load on accept, retire when its result leaves for a response slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_owner <= 1'b0;
      iss_a     <= 32'd0;
      iss_b     <= 32'd0;
      iss_op    <= 3'b000;
      ptr       <= 1'b0;
    end else if (accept) begin
      iss_valid <= 1'b1;
      iss_owner <= acc_id;
      iss_a     <= acc_id ? req_a1 : req_a0;
      iss_b     <= acc_id ? req_b1 : req_b0;
      iss_op    <= acc_id ? req_op1 : req_op0;
      ptr       <= ~acc_id;
    end else if (iss_move) begin
      iss_valid <= 1'b0;
    end
  end

  // Per-requester response slots; a reload in the same cycle as a pop keeps the slot valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 2'b00;
      rsp_res0  <= 32'd0;
      rsp_res1  <= 32'd0;
      rsp_zero0 <= 1'b0;
      rsp_zero1 <= 1'b0;
    end else begin
      if (iss_move && !iss_owner) begin
        rsp_valid[0] <= 1'b1;
        rsp_res0     <= alu_res;
        rsp_zero0    <= alu_zero;
      end else if (rsp_valid[0] && rsp_ready[0]) begin
        rsp_valid[0] <= 1'b0;
      end
      if (iss_move && iss_owner) begin
        rsp_valid[1] <= 1'b1;
        rsp_res1     <= alu_res;
        rsp_zero1    <= alu_zero;
      end else if (rsp_valid[1] && rsp_ready[1]) begin
        rsp_valid[1] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_op0, req_op1;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_res0, rsp_res1;
  logic        rsp_zero0, rsp_zero1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res0(rsp_res0), .rsp_res1(rsp_res1),
    .rsp_zero0(rsp_zero0), .rsp_zero1(rsp_zero1)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b011:  return a ^ b;
      3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // The shared ALU lives in the bench
  always_comb begin
    alu_res  = alu_fn(alu_a, alu_b, alu_ctrl);
    alu_zero = (alu_res == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: one pending op in flight, one held result per requester
  bit          m_busy;
  bit          m_own;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  bit          m_ptr;
  bit          m_rv [2];
  logic [31:0] m_res [2];
  bit          m_z [2];
  logic [32:0] sbq0[$];
  logic [32:0] sbq1[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      check("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_rsp_res1", rsp_res1, 32'd0);
      m_busy = 0; m_own = 0; m_a = 0; m_b = 0; m_op = 0; m_ptr = 0;
      for (int i = 0; i < 2; i++) begin m_rv[i] = 0; m_res[i] = 0; m_z[i] = 0; end
      sbq0.delete(); sbq1.delete();
    end else begin
      bit         slot_open, moving, pick;
      logic [1:0] exp_rdy;
      logic [32:0] front;
      slot_open = !m_rv[m_own] || rsp_ready[m_own];
      moving    = m_busy && slot_open;
      if (req_valid == 2'b11) pick = m_ptr;
      else pick = req_valid[1];
      exp_rdy = ((!m_busy || moving) && req_valid != 2'b00) ? (pick ? 2'b10 : 2'b01) : 2'b00;

      check("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
      check("rsp_valid", {30'd0, rsp_valid}, {30'd0, m_rv[1], m_rv[0]});
      check("rsp_res0", rsp_res0, m_res[0]);
      check("rsp_res1", rsp_res1, m_res[1]);
      check("rsp_zero", {30'd0, rsp_zero1, rsp_zero0}, {30'd0, m_z[1], m_z[0]});
      if (m_busy) begin
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, m_op});
      end

      // In-order scoreboard on consumed responses
      if (rsp_valid[0] && rsp_ready[0]) begin
        if (sbq0.size() == 0) check("sb0_underflow", 32'd1, 32'd0);
        else begin front = sbq0.pop_front(); check("sb0_order", {rsp_zero0, rsp_res0}, front); end
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
        if (sbq1.size() == 0) check("sb1_underflow", 32'd1, 32'd0);
        else begin front = sbq1.pop_front(); check("sb1_order", {rsp_zero1, rsp_res1}, front); end
      end

      for (int i = 0; i < 2; i++) if (m_rv[i] && rsp_ready[i]) m_rv[i] = 0;
      if (moving) begin
        m_res[m_own] = alu_fn(m_a, m_b, m_op);
        m_z[m_own]   = (m_res[m_own] == 32'd0);
        m_rv[m_own]  = 1;
        m_busy       = 0;
      end
      if (exp_rdy != 2'b00) begin
        logic [31:0] r;
        m_busy = 1;
        m_own  = pick;
        m_a    = pick ? req_a1 : req_a0;
        m_b    = pick ? req_b1 : req_b0;
        m_op   = pick ? req_op1 : req_op0;
        m_ptr  = !pick;
        r = alu_fn(m_a, m_b, m_op);
        if (pick) sbq1.push_back({r == 32'd0, r});
        else sbq0.push_back({r == 32'd0, r});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op0 = op; req_a0 = a; req_b0 = b;
  endtask

  task automatic drive1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op1 = op; req_a1 = a; req_b1 = b;
  endtask

  initial begin
    int n0, n1;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0; req_op0 = 0; req_op1 = 0;
    #2;
    check("init_req_ready", {30'd0, req_ready}, 32'd0);
    check("init_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD 5,7 from requester 0
    rsp_ready = 2'b11;
    drive0(3'b010, 32'd5, 32'd7); req_valid = 2'b01;
    #1 check("t1_ready", {30'd0, req_ready}, 32'd1);
    tick(); req_valid = 2'b00;
    check("t1_alu_ctrl", {29'd0, alu_ctrl}, 32'd2);
    check("t1_no_rsp_yet", {30'd0, rsp_valid}, 32'd0);
    tick();
    check("t1_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    check("t1_res", rsp_res0, 32'd12);
    check("t1_zero", {31'd0, rsp_zero0}, 32'd0);
    tick();

    // SUB equal operands then signed SLT, back-to-back on requester 1
    drive1(3'b110, 32'h1234, 32'h1234); req_valid = 2'b10;
    #1 check("t2_ready", {30'd0, req_ready}, 32'd2);
    tick();
    drive1(3'b100, 32'hFFFF_FFFF, 32'd1);
    #1 check("t2_ready_b2b", {30'd0, req_ready}, 32'd2);
    tick(); req_valid = 2'b00;
    check("t2_sub_res", rsp_res1, 32'd0);
    check("t2_sub_zero", {31'd0, rsp_zero1}, 32'd1);
    tick();
    check("t2_slt_valid", {30'd0, rsp_valid}, 32'd2);
    check("t2_slt_res", rsp_res1, 32'd1);
    check("t2_slt_zero", {31'd0, rsp_zero1}, 32'd0);
    tick();

    // Head-of-line blocking behind a stalled requester-0 slot
    rsp_ready = 2'b10;
    drive0(3'b010, 32'd1, 32'd2); req_valid = 2'b01;
    tick();
    drive0(3'b001, 32'hF0, 32'h0F);
    tick();
    drive1(3'b011, 32'hFF, 32'h0F); req_valid = 2'b10;
    #1 check("t4_blocked", {30'd0, req_ready}, 32'd0);
    check("t4_slot0", rsp_res0, 32'd3);
    tick();
    check("t4_still_blocked", {30'd0, req_ready}, 32'd0);
    check("t4_held_op", {29'd0, alu_ctrl}, 32'd1);
    check("t4_stable", rsp_res0, 32'd3);
    rsp_ready = 2'b11;
    #1 check("t4_unblock", {30'd0, req_ready}, 32'd2);
    tick(); req_valid = 2'b00;
    check("t4_reload_valid", {31'd0, rsp_valid[0]}, 32'd1);
    check("t4_reload_res", rsp_res0, 32'hFF);
    check("t4_req1_issued", {29'd0, alu_ctrl}, 32'd3);
    tick();
    check("t4_req1_res", rsp_res1, 32'hF0);
    tick();

    // Fairness with both requesters continuously valid
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      req_valid = {n1 < 4, n0 < 4};
      drive0(3'b010, n0 + 1, 32'd100);
      drive1(3'b010, n1, 32'd1000);
      #1 check("t3_grant", {30'd0, req_ready}, (k % 2) ? 32'd2 : 32'd1);
      if (req_ready[0]) n0++;
      if (req_ready[1]) n1++;
      tick();
    end
    req_valid = 2'b00;
    repeat (3) tick();

    // Undefined opcode returns zero
    drive0(3'b111, 32'd3, 32'd5); req_valid = 2'b01;
    tick(); req_valid = 2'b00;
    tick();
    check("t5_res", rsp_res0, 32'd0);
    check("t5_zero", {31'd0, rsp_zero0}, 32'd1);
    tick();

    // Reset with an op in issue and a pending response
    rsp_ready = 2'b00;
    drive0(3'b000, 32'hF, 32'h3); req_valid = 2'b01;
    tick();
    drive0(3'b010, 32'd2, 32'd2);
    tick(); req_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rsp_cleared", {30'd0, rsp_valid}, 32'd0);
    check("t6_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    tick();
    rst_n = 1'b1; rsp_ready = 2'b11;
    drive0(3'b010, 32'd9, 32'd1); drive1(3'b010, 32'd8, 32'd1); req_valid = 2'b11;
    #1 check("t6_first_tie", {30'd0, req_ready}, 32'd1);
    tick(); req_valid = 2'b00;
    repeat (3) tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      req_b0 = $urandom; req_b1 = $urandom;
      req_a0 = ($urandom_range(0, 3) == 0) ? req_b0 : $urandom;
      req_a1 = ($urandom_range(0, 3) == 0) ? req_b1 : $urandom;
      req_op0 = 3'($urandom_range(0, 7));
      req_op1 = 3'($urandom_range(0, 7));
      tick();
    end

    // Drain and confirm every accepted op was delivered
    req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (6) tick();
    check("drain_q0", sbq0.size(), 32'd0);
    check("drain_q1", sbq1.size(), 32'd0);
    check("drain_rsp_valid", {30'd0, rsp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter that shares one instance of the team's combinational ALU between two requesters, e.g. the EX stage and the branch/address unit. It accepts operand/opcode requests over valid/ready handshakes, drives the shared ALU from a registered issue stage, and returns each result and zero flag to its owner through a one-entry response buffer per requester. Throughput is one operation per cycle; minimum accept-to-response latency is 2 cycles.

## Interface
- No parameters. Data width fixed at 32, opcode width fixed at 3.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid[1:0]  in  2  request valid, bit i = requester i
- req_ready[1:0]  out  2  request accepted this cycle when valid & ready
- req_a0, req_b0, req_a1, req_b1  in  32 each  operands, requester 0 / 1
- req_op0, req_op1  in  3 each  ALU opcode, requester 0 / 1
- alu_a, alu_b  out  32 each  operands to the shared ALU
- alu_ctrl  out  3  opcode to the shared ALU
- alu_res  in  32  ALU result, combinational on alu_a/alu_b/alu_ctrl
- alu_zero  in  1  ALU zero flag, 1 iff alu_res == 0
- rsp_valid[1:0]  out  2  response valid per requester
- rsp_ready[1:0]  in  2  response consumed when valid & ready
- rsp_res0, rsp_res1  out  32 each  result per requester
- rsp_zero0, rsp_zero1  out  1 each  zero flag per requester

## Operation
- The arbiter passes opcodes through unchanged. ALU encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 011 XOR, 100 signed SLT (result 1/0). Any other opcode makes the ALU return 0, so zero = 1. The arbiter does not flag these as errors.
- Issue register: iss_valid, iss_owner, iss_a, iss_b, iss_op. alu_a/alu_b/alu_ctrl are driven directly from iss_a/iss_b/iss_op.
- iss_move = iss_valid & (!rsp_valid[iss_owner] | rsp_ready[iss_owner]).
- iss_free = !iss_valid | iss_move.
- Grant: if only one requester is valid, that requester gets the grant. If both are valid, the grant goes to the requester selected by the 1-bit priority pointer ptr.
- req_ready[i] = iss_free & grant[i]. At most one bit is set. It is 0 when no request is valid.
- On accept: load the issue register with the requester's operands and opcode, set iss_owner = i, and set ptr = ~i.
- On iss_move: capture alu_res/alu_zero into response slot iss_owner and set rsp_valid[iss_owner]. If nothing is accepted in the same cycle, clear iss_valid.
- Response pop: when rsp_valid[i] & rsp_ready[i], clear rsp_valid[i] unless the slot is reloaded by iss_move in the same cycle. If reloaded, it stays 1 with the new data.
- Head-of-line blocking: a stalled response slot for the issue owner stalls the issue register and blocks both requesters. This is intended.
- Ordering: responses to one requester return in acceptance order.

## Timing
- Reset (async assert, sync use after deassert):
  - req_ready = 0 until the first cycle with iss_free and a valid request.
  - iss_valid = 0, iss_a = iss_b = 0, iss_op = 000, so alu_a = alu_b = 0 and alu_ctrl = 000.
  - rsp_valid = 00, rsp_res0 = rsp_res1 = 0, rsp_zero0 = rsp_zero1 = 0.
  - ptr = 0 (requester 0 wins the first tie).
- Reset asserted mid-operation drops all in-flight requests and responses immediately. Nothing is replayed.
- Latency: accepted at edge E0, the op is on the ALU during cycle E0→E1, captured at E1 if its slot is free, and rsp_valid is 1 in the cycle after E1.
- Back-to-back: a new request can be accepted at every edge while iss_move holds.
- Simultaneous accept, issue move and response pop in one cycle is legal and loses no data.
- rsp_res/rsp_zero stay stable while rsp_valid = 1 and rsp_ready = 0.
- req_ready depends combinationally on req_valid and rsp_ready. Requesters must not make req_valid depend on req_ready.

## Test plan
- Requester 0 sends ADD 5, 7 with rsp_ready = 11 -> req_ready0 = 1 at E0; rsp_valid0 = 1 with rsp_res0 = 12 and rsp_zero0 = 0 two cycles later.
- Requester 1 sends SUB 0x1234, 0x1234 then SLT 0xFFFFFFFF, 1 back-to-back -> responses 0 with zero = 1, then 1 with zero = 0, on consecutive cycles.
- Both requesters valid continuously, each with 4 ADDs, rsp_ready = 11 -> grants strictly 0,1,0,1,…; each requester gets its 4 results in order.
- rsp_ready0 = 0 with two requester-0 ops outstanding -> the second op holds in the issue register; req_ready = 00 even with req1 valid. Raising rsp_ready0 drains both in order and the pending req1 is then accepted.
- Opcode 111 with operands 3, 5 -> rsp_res = 0 and rsp_zero = 1.
- rst_n pulsed low while an op is in the issue register and a response is pending -> rsp_valid = 00 and alu_ctrl = 000 immediately; after release, requester 0 wins the first tie.
